// File: rtl/sprite_line_fetch.sv
// Sprite line fetcher: pulls one 16-pixel sprite row from ROM during
// horizontal blanking into a line buffer, then serves pixels by hcount.
module sprite_line_fetch #(
  parameter logic [15:0] TRANSPARENT = 16'hF81F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [9:0]  vcount,
  input  logic [9:0]  hcount,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic        sprite_en,
  output logic [7:0]  rom_address,
  output logic        rom_clken,
  input  logic [15:0] rom_readdata,
  output logic        pixel_valid,
  output logic [15:0] pixel_rgb,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t      state;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        buf_valid;
  logic [15:0] line_buf [16];

  logic [10:0] row_diff;
  logic [10:0] dx;
  logic        hit;
  logic        pix_in;
  logic [15:0] pix_word;

  assign row_diff = {1'b0, vcount} - {1'b0, sprite_y};
  assign hit      = sprite_en && !row_diff[10] && (row_diff[9:4] == 6'd0);

  assign dx       = {1'b0, hcount} - {1'b0, sprite_x};
  assign pix_word = line_buf[dx[3:0]];
  assign pix_in   = buf_valid && !busy && !dx[10]
                 && (dx[9:4] == 6'd0) && (pix_word != TRANSPARENT);

  // Fetch sequencer; a new line_start always restarts from scratch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      buf_valid   <= 1'b0;
      row         <= 4'd0;
      col         <= 4'd0;
      rom_clken   <= 1'b0;
      rom_address <= 8'd0;
    end else if (line_start) begin
      buf_valid <= 1'b0;
      if (hit) begin
        state       <= FETCH;
        busy        <= 1'b1;
        row         <= row_diff[3:0];
        col         <= 4'd0;
        rom_clken   <= 1'b1;
        rom_address <= {row_diff[3:0], 4'd0};
      end else begin
        state     <= IDLE;
        busy      <= 1'b0;
        rom_clken <= 1'b0;
      end
    end else begin
      case (state)
        FETCH: begin
          if (col == 4'd15) begin
            state     <= DRAIN;
            rom_clken <= 1'b0;
          end else begin
            col         <= col + 4'd1;
            rom_address <= {row, col + 4'd1};
          end
        end
        DRAIN: begin
          state     <= IDLE;
          busy      <= 1'b0;
          buf_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Capture ROM data one cycle behind each address issue.
  always_ff @(posedge clk) begin
    if (!reset && !line_start) begin
      if (state == FETCH && col != 4'd0)
        line_buf[col - 4'd1] <= rom_readdata;
      else if (state == DRAIN)
        line_buf[4'd15] <= rom_readdata;
    end
  end

  // Pixel output stage, one cycle behind hcount.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_valid <= 1'b0;
      pixel_rgb   <= 16'd0;
    end else begin
      pixel_valid <= pix_in;
      pixel_rgb   <= pix_in ? pix_word : 16'd0;
    end
  end

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Testbench for sprite_line_fetch: ROM model plus a behavioural
// line/pixel reference compared against the DUT.
module tb_sprite_line_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [9:0]  vcount;
  logic [9:0]  hcount;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic        sprite_en;
  logic [7:0]  rom_address;
  logic        rom_clken;
  logic [15:0] rom_readdata;
  logic        pixel_valid;
  logic [15:0] pixel_rgb;
  logic        busy;

  logic [15:0] rom [256];
  logic [15:0] rom_q = 16'd0;

  logic [15:0] mbuf [16];
  bit          mvalid;

  int errors = 0;
  int checks = 0;

  sprite_line_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .line_start   (line_start),
    .vcount       (vcount),
    .hcount       (hcount),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .sprite_en    (sprite_en),
    .rom_address  (rom_address),
    .rom_clken    (rom_clken),
    .rom_readdata (rom_readdata),
    .pixel_valid  (pixel_valid),
    .pixel_rgb    (pixel_rgb),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rom_clken) rom_q <= rom[rom_address];
  assign rom_readdata = rom_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rom_ident();
    for (int i = 0; i < 256; i++) rom[i] = 16'(i);
  endtask

  // Pulse line_start and follow the fetch; update the reference buffer.
  task automatic run_line(input int vc, input bit en,
                          output int n_busy, output int n_clk);
    int r;
    bit hit;
    logic [7:0] ea;
    r   = vc - int'(sprite_y);
    hit = en && r >= 0 && r < 16;
    vcount     = 10'(vc);
    sprite_en  = en;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    n_busy = 0;
    n_clk  = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy) n_busy++;
      if (rom_clken) begin
        ea = 8'(r * 16 + n_clk);
        checks++;
        if (rom_address !== ea) begin
          errors++;
          $display("FAIL fetch_addr idx=%0d got=%h exp=%h",
                   n_clk, rom_address, ea);
        end
        n_clk++;
      end
      tick();
    end
    if (hit) begin
      for (int c = 0; c < 16; c++) mbuf[c] = rom[r * 16 + c];
      mvalid = 1'b1;
    end else begin
      mvalid = 1'b0;
    end
  endtask

  task automatic check_line(input string nm, input int vc, input bit en,
                            input bit exp_hit);
    int nb, nc;
    run_line(vc, en, nb, nc);
    checks++;
    if (nb != (exp_hit ? 17 : 0)) begin
      errors++;
      $display("FAIL %s_busy got=%0d exp=%0d", nm, nb, exp_hit ? 17 : 0);
    end
    checks++;
    if (nc != (exp_hit ? 16 : 0)) begin
      errors++;
      $display("FAIL %s_clken got=%0d exp=%0d", nm, nc, exp_hit ? 16 : 0);
    end
  endtask

  // Sweep hcount; each output is compared one cycle after its hcount.
  task automatic sweep(input string nm, input int lo, input int hi,
                       output int nvalid);
    int dx;
    bit ev;
    logic [15:0] er;
    nvalid = 0;
    for (int h = lo; h <= hi; h++) begin
      hcount = 10'(h);
      tick();
      dx = h - int'(sprite_x);
      ev = mvalid && dx >= 0 && dx < 16 && mbuf[dx[3:0]] != 16'hF81F;
      er = ev ? mbuf[dx[3:0]] : 16'd0;
      if (pixel_valid) nvalid++;
      checks++;
      if (pixel_valid !== ev || pixel_rgb !== er) begin
        errors++;
        $display("FAIL %s_pix h=%0d got=%b/%h exp=%b/%h",
                 nm, h, pixel_valid, pixel_rgb, ev, er);
      end
    end
    hcount = 10'd0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    line_start = 1'b0;
    vcount     = 10'd0;
    hcount     = 10'd0;
    sprite_x   = 10'd200;
    sprite_y   = 10'd100;
    sprite_en  = 1'b1;
    mvalid     = 1'b0;
    rom_ident();
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({rom_address, rom_clken, busy, pixel_valid, pixel_rgb} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outs got=%h/%b/%b/%b/%h exp=0",
               rom_address, rom_clken, busy, pixel_valid, pixel_rgb);
    end
  endtask

  task automatic test_fetch();
    int nv;
    check_line("fetch", 103, 1'b1, 1'b1);
    sprite_x = 10'd200;
    sweep("sweep", 190, 220, nv);
    checks++;
    if (nv != 16) begin
      errors++;
      $display("FAIL sweep_count got=%0d exp=16", nv);
    end
  endtask

  task automatic test_transparent();
    int nv;
    rom[8'h35] = 16'hF81F;
    check_line("transp", 103, 1'b1, 1'b1);
    sweep("transp", 190, 220, nv);
    checks++;
    if (nv != 15) begin
      errors++;
      $display("FAIL transp_count got=%0d exp=15", nv);
    end
    rom_ident();
  endtask

  task automatic test_miss();
    int nv;
    check_line("miss99", 99, 1'b1, 1'b0);
    sweep("miss99", 190, 220, nv);
    check_line("fill", 103, 1'b1, 1'b1);
    check_line("miss116", 116, 1'b1, 1'b0);
    sweep("miss116", 190, 220, nv);
    check_line("fill2", 103, 1'b1, 1'b1);
    check_line("miss_en", 103, 1'b0, 1'b0);
    sweep("miss_en", 190, 220, nv);
    sprite_y = 10'd1020;
    check_line("miss_wrap", 5, 1'b1, 1'b0);
    sweep("miss_wrap", 190, 220, nv);
    sprite_y = 10'd100;
  endtask

  task automatic test_abort();
    int nv;
    vcount     = 10'd103;
    sprite_en  = 1'b1;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check_line("abort", 104, 1'b1, 1'b1);
    sweep("abort", 190, 220, nv);
    checks++;
    if (nv != 16) begin
      errors++;
      $display("FAIL abort_count got=%0d exp=16", nv);
    end
  endtask

  task automatic test_reset_mid();
    int nv;
    vcount     = 10'd103;
    sprite_en  = 1'b1;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({rom_address, rom_clken, busy, pixel_valid, pixel_rgb} !== 27'd0) begin
      errors++;
      $display("FAIL rstmid_outs got=%h/%b/%b/%b/%h exp=0",
               rom_address, rom_clken, busy, pixel_valid, pixel_rgb);
    end
    reset  = 1'b0;
    mvalid = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    sweep("rstmid", 190, 220, nv);
  endtask

  task automatic test_random();
    int nv, vc, r, lo, hi;
    bit en, hit;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 256; i++)
        rom[i] = ($urandom_range(0, 5) == 0) ? 16'hF81F : 16'($urandom);
      sprite_y = 10'($urandom_range(0, 1023));
      vc       = int'(sprite_y) + $urandom_range(0, 22) - 3;
      if (vc < 0) vc = 0;
      if (vc > 1023) vc = 1023;
      en       = ($urandom_range(0, 4) != 0);
      r        = vc - int'(sprite_y);
      hit      = en && r >= 0 && r < 16;
      sprite_x = 10'($urandom_range(0, 1023));
      check_line("rand", vc, en, hit);
      lo = int'(sprite_x) - 3;
      hi = int'(sprite_x) + 18;
      if (lo < 0) lo = 0;
      if (hi > 1023) hi = 1023;
      sweep("rand", lo, hi, nv);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_transparent();
    test_miss();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
